// File: rtl/gascore_mem_responder.sv
// gascore_mem_responder: AXI4 slave backed by a 64-bit internal RAM.
// Independent write/read FSMs, INCR/FIXED bursts, SLVERR when out of range.
module gascore_mem_responder #(
    parameter int MEM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int WORD_W = ADDR_WIDTH - 3;
    localparam logic [WORD_W-1:0]     DEPTH_LIM  = WORD_W'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(8);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    w_state_t              r_wstate;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wbeat;
    logic                  r_wfixed;
    logic                  r_werr;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    r_state_t              r_rstate;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rbeat;
    logic                  r_rfixed;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_wr_inrange;
    logic                  w_wr_last;
    logic                  w_wr_bad;
    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_widx;
    logic                  w_rd_inrange;
    logic [IDX_W-1:0]      w_ridx;
    logic                  w_unused;

    assign w_wr_inrange = (r_waddr[ADDR_WIDTH-1:3] < DEPTH_LIM);
    assign w_wr_last    = (r_wbeat == r_wlen);
    assign w_wr_bad     = !w_wr_inrange || (s_axi_wlast != w_wr_last);
    assign w_wr_en      = reset_n && (r_wstate == W_DATA) &&
                          s_axi_wvalid && w_wr_inrange;
    assign w_widx       = r_waddr[3 +: IDX_W];
    assign w_rd_inrange = (r_raddr[ADDR_WIDTH-1:3] < DEPTH_LIM);
    assign w_ridx       = r_raddr[3 +: IDX_W];

    // Beats are always full words, so size and the byte offset play no part
    assign w_unused = ^{s_axi_awsize, s_axi_arsize,
                        r_waddr[2:0], r_raddr[2:0]};

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;

    // Write channel: accept AW, consume exactly len+1 beats, then respond on B
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wstate  <= W_IDLE;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wbeat   <= '0;
            r_wfixed  <= 1'b0;
            r_werr    <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (s_axi_awvalid) begin
                        r_waddr   <= s_axi_awaddr;
                        r_wlen    <= s_axi_awlen;
                        r_wfixed  <= (s_axi_awburst == 2'b00);
                        r_wbeat   <= '0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        if (!r_wfixed) begin
                            r_waddr <= r_waddr + BEAT_BYTES;
                        end
                        r_wbeat <= r_wbeat + 8'd1;
                        r_werr  <= r_werr | w_wr_bad;
                        if (w_wr_last) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_wr_bad) ? 2'b10 : 2'b00;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'b00;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Byte-lane RAM write; out-of-range beats never reach the array
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[w_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read channel: fetch one word per beat, hold it on R until accepted
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rstate  <= R_IDLE;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
            r_rfixed  <= 1'b0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        r_raddr   <= s_axi_araddr;
                        r_rlen    <= s_axi_arlen;
                        r_rfixed  <= (s_axi_arburst == 2'b00);
                        r_rbeat   <= '0;
                        r_arready <= 1'b0;
                        r_rstate  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    r_rdata  <= w_rd_inrange ? r_mem[w_ridx] : '0;
                    r_rresp  <= w_rd_inrange ? 2'b00 : 2'b10;
                    r_rlast  <= (r_rbeat == r_rlen);
                    r_rvalid <= 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_rlast) begin
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            if (!r_rfixed) begin
                                r_raddr <= r_raddr + BEAT_BYTES;
                            end
                            r_rbeat  <= r_rbeat + 8'd1;
                            r_rstate <= R_FETCH;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule
